fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one-cycle-latency memory reads into a
// 2-entry buffer, presents the head to the decoder and stops after a halt retires.
module fetch_unit #(
   parameter int                    PC_BITS    = 12,
   parameter int                    INSTR_BITS = 9,
   parameter logic [INSTR_BITS-1:0] HALT_OP    = '1
) (
   input  logic                  clock,
   input  logic                  start,
   input  logic [PC_BITS-1:0]    pc,
   output logic                  pc_stall,
   input  logic                  jump_flush,
   output logic                  imem_en,
   output logic [PC_BITS-1:0]    imem_addr,
   input  logic [INSTR_BITS-1:0] imem_data,
   output logic [INSTR_BITS-1:0] instr,
   output logic [PC_BITS-1:0]    instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic                  done,
   output logic [15:0]           retired
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              count_q, count_d;
   logic                    inflight_q, inflight_d;
   logic [PC_BITS-1:0]      reqAddr_q, reqAddr_d;
   logic [INSTR_BITS-1:0]   word0_q, word0_d, word1_q, word1_d;
   logic [PC_BITS-1:0]      addr0_q, addr0_d, addr1_q, addr1_d;
   logic [15:0]             retired_q, retired_d;

   logic       issue;
   logic       accept;
   logic       push;
   logic [2:0] occupancy;

   always_ff @(posedge clock) begin
      if (start) begin
         state_q    <= IDLE;
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
         reqAddr_q  <= '0;
         word0_q    <= '0;
         word1_q    <= '0;
         addr0_q    <= '0;
         addr1_q    <= '0;
         retired_q  <= 16'd0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         reqAddr_q  <= reqAddr_d;
         word0_q    <= word0_d;
         word1_q    <= word1_d;
         addr0_q    <= addr0_d;
         addr1_q    <= addr1_d;
         retired_q  <= retired_d;
      end
   end

   // Issue only counts slots already committed (buffered plus in flight), so
   // the buffer can never overflow even without looking at the pop.
   always_comb begin
      occupancy   = {1'b0, count_q} + {2'b00, inflight_q};
      issue       = (state_q == RUN) && !jump_flush && (occupancy < 3'd2);
      instr_valid = (count_q != 2'd0) && (state_q == RUN);
      accept      = instr_valid && instr_ready;
      push        = inflight_q && (state_q == RUN) && !jump_flush;
      pc_stall    = !issue;
      imem_en     = issue;
      imem_addr   = issue ? pc : '0;
      instr       = word0_q;
      instr_pc    = addr0_q;
      done        = (state_q == DONE);
      retired     = retired_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (accept && (word0_q == HALT_OP)) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Head sits in entry 0; a pop shifts entry 1 down while a push fills the
   // first free slot after that shift, which keeps order on push+pop.
   always_comb begin
      count_d    = count_q;
      word0_d    = word0_q;
      word1_d    = word1_q;
      addr0_d    = addr0_q;
      addr1_d    = addr1_q;
      inflight_d = issue;
      reqAddr_d  = issue ? pc : reqAddr_q;
      retired_d  = (accept && (retired_q != 16'hFFFF)) ? retired_q + 16'd1 : retired_q;
      if (jump_flush) begin
         count_d = 2'd0;
      end else if (push && accept) begin
         if (count_q == 2'd1) begin
            word0_d = imem_data;
            addr0_d = reqAddr_q;
         end else begin
            word0_d = word1_q;
            addr0_d = addr1_q;
            word1_d = imem_data;
            addr1_d = reqAddr_q;
         end
      end else if (push) begin
         if (count_q == 2'd0) begin
            word0_d = imem_data;
            addr0_d = reqAddr_q;
         end else begin
            word1_d = imem_data;
            addr1_d = reqAddr_q;
         end
         count_d = count_q + 2'd1;
      end else if (accept) begin
         word0_d = word1_q;
         addr0_d = addr1_q;
         count_d = count_q - 2'd1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a PC/ROM model drives the block and a
// scoreboard of expected addresses is checked against every accepted word.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        start = 1'b1;
   logic [11:0] pc;
   logic        pc_stall;
   logic        jump_flush = 1'b0;
   logic        imem_en;
   logic [11:0] imem_addr;
   logic [8:0]  imem_data = 9'd0;
   logic [8:0]  instr;
   logic [11:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        done;
   logic [15:0] retired;

   logic [11:0] pcReg = 12'd0;
   logic [11:0] jumpTarget = 12'd0;
   logic        haltEn = 1'b0;
   logic [11:0] haltAddr = 12'd0;
   int          checks = 0;
   int          errors = 0;
   logic [11:0] expQ[$];

   fetch_unit dut (
      .clock(clock), .start(start), .pc(pc), .pc_stall(pc_stall),
      .jump_flush(jump_flush), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .done(done),
      .retired(retired)
   );

   always #5 clock = ~clock;

   assign pc = pcReg;

   function automatic logic [8:0] romWord(input logic [11:0] a);
      if (haltEn && (a == haltAddr)) return 9'h1FF;
      return a[8:0];
   endfunction

   // External program counter: advances whenever the fetch unit does not stall it.
   always @(posedge clock) begin
      if (start)             pcReg <= 12'd0;
      else if (jump_flush)   pcReg <= jumpTarget;
      else if (!pc_stall)    pcReg <= pcReg + 12'd1;
   end

   always @(posedge clock) begin
      if (imem_en) imem_data <= romWord(imem_addr);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Scoreboard pops one expected address per handshake.
   always @(negedge clock) begin
      if (!start && (instr_valid === 1'b1) && (instr_ready === 1'b1)) begin
         checks++;
         assert (expQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL sb_extra observed_pc=%0h expected=none", instr_pc);
         end
         if (expQ.size() > 0) begin
            logic [11:0] e;
            e = expQ.pop_front();
            checkOutput("sb_pc", {20'd0, instr_pc}, {20'd0, e});
            checkOutput("sb_instr", {23'd0, instr}, {23'd0, romWord(e)});
         end
      end
   end

   task automatic applyStimulus(input logic s, input logic f, input logic r);
      @(posedge clock);
      #1;
      start = s;
      jump_flush = f;
      instr_ready = r;
      @(negedge clock);
      #1;
   endtask

   task automatic pushRange(input logic [11:0] base, input int n);
      for (int i = 0; i < n; i++) expQ.push_back(base + 12'(i));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      checkOutput({tag, "_imem_en"}, {31'd0, imem_en}, 32'd0);
      checkOutput({tag, "_imem_addr"}, {20'd0, imem_addr}, 32'd0);
      checkOutput({tag, "_instr"}, {23'd0, instr}, 32'd0);
      checkOutput({tag, "_instr_pc"}, {20'd0, instr_pc}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_retired"}, {16'd0, retired}, 32'd0);
      checkOutput({tag, "_pc_stall"}, {31'd0, pc_stall}, 32'd1);
   endtask

   // Two cycles of start, then leaves the bench in the release cycle (IDLE, start low).
   task automatic restart(input logic r);
      applyStimulus(1'b1, 1'b0, r);
      applyStimulus(1'b1, 1'b0, r);
      expQ.delete();
      applyStimulus(1'b0, 1'b0, r);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Basic streaming with ready held high.
      restart(1'b1);
      checkResetOutputs("reset");
      pushRange(12'd0, 20);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("a1_stall", {31'd0, pc_stall}, 32'd0);
      checkOutput("a1_en", {31'd0, imem_en}, 32'd1);
      checkOutput("a1_addr", {20'd0, imem_addr}, 32'd0);
      checkOutput("a1_valid", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("a2_addr", {20'd0, imem_addr}, 32'd1);
      checkOutput("a2_valid", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("a3_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("a3_pc", {20'd0, instr_pc}, 32'd0);
      checkOutput("a3_stall", {31'd0, pc_stall}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("a4_retired", {16'd0, retired}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("a5_retired", {16'd0, retired}, 32'd2);
      checkOutput("a5_valid", {31'd0, instr_valid}, 32'd0);
      for (int k = 6; k <= 11; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("a11_retired", {16'd0, retired}, 32'd6);

      // Backpressure: buffer fills, then drains in order.
      restart(1'b0);
      pushRange(12'd0, 20);
      for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("b_full_stall", {31'd0, pc_stall}, 32'd1);
      checkOutput("b_full_en", {31'd0, imem_en}, 32'd0);
      checkOutput("b_full_pc", {20'd0, instr_pc}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("b_hold_en", {31'd0, imem_en}, 32'd0);
      for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 1'b1);

      // Flush with one word buffered and one read in flight.
      restart(1'b0);
      jumpTarget = 12'd470;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("c_flush_en", {31'd0, imem_en}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("c_post_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("c_post_addr", {20'd0, imem_addr}, 32'd470);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("c_post2_valid", {31'd0, instr_valid}, 32'd0);
      expQ.delete();
      pushRange(12'd470, 10);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("c_target_pc", {20'd0, instr_pc}, 32'd470);
      for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b1);

      // Flush with a full buffer while the head is accepted.
      restart(1'b0);
      jumpTarget = 12'd100;
      pushRange(12'd0, 1);
      for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      expQ.delete();
      pushRange(12'd100, 10);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("d_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("d_retired", {16'd0, retired}, 32'd1);
      checkOutput("d_addr", {20'd0, imem_addr}, 32'd100);
      for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b1);

      // Halt at address 5.
      haltEn = 1'b1;
      haltAddr = 12'd5;
      restart(1'b1);
      pushRange(12'd0, 6);
      for (int k = 1; k <= 10; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("e_pre_done", {31'd0, done}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("e_done", {31'd0, done}, 32'd1);
      checkOutput("e_retired", {16'd0, retired}, 32'd6);
      checkOutput("e_valid", {31'd0, instr_valid}, 32'd0);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("e_idle_en", {31'd0, imem_en}, 32'd0);
      checkOutput("e_hold_done", {31'd0, done}, 32'd1);
      checkOutput("e_hold_retired", {16'd0, retired}, 32'd6);

      // Halt retired together with a jump_flush.
      restart(1'b1);
      jumpTarget = 12'd200;
      pushRange(12'd0, 6);
      for (int k = 1; k <= 9; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("f_done", {31'd0, done}, 32'd1);
      checkOutput("f_retired", {16'd0, retired}, 32'd6);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("f_en", {31'd0, imem_en}, 32'd0);
      haltEn = 1'b0;

      // Start asserted mid-run with a word buffered and a read in flight.
      restart(1'b1);
      pushRange(12'd0, 3);
      for (int k = 1; k <= 5; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("g_pre_retired", {16'd0, retired}, 32'd2);
      applyStimulus(1'b1, 1'b0, 1'b1);
      expQ.delete();
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkResetOutputs("g_reset");
      pushRange(12'd0, 10);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("g_restart_en", {31'd0, imem_en}, 32'd1);
      checkOutput("g_restart_addr", {20'd0, imem_addr}, 32'd0);
      for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b1);

      // Retired counter saturation.
      restart(1'b0);
      pushRange(12'd0, 10);
      for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b0, 1'b0);
      force dut.retired_q = 16'hFFFE;
      applyStimulus(1'b0, 1'b0, 1'b0);
      release dut.retired_q;
      #1;
      checkOutput("h_preset", {16'd0, retired}, 32'h0000FFFE);
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("h_sat", {16'd0, retired}, 32'h0000FFFF);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("h_sat_hold", {16'd0, retired}, 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
